// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: NCH prioritised, maskable, optionally nestable sources.
// Latency: boundary -> int_req 1 cycle; int_ack -> vec_vld 1 cycle; pulse -> pending 3 cycles.
// Backpressure: a selected request is held on int_req until int_ack; later edges just stay pending.
//
// Ports:
//   t3          clock, all state updates on its falling edge
//   clr         asynchronous active-low reset
//   pulse       raw request lines, asynchronous to t3 (must stay high >= 2 t3 periods)
//   mask_wr     load mask register from mask_in (1 = channel masked)
//   ei / di     enable / disable strobes from the decoded instruction
//   boundary    last beat of the current instruction
//   int_ack     controller has entered the interrupt-entry sequence
//   iret        IRET executing
//   int_req     request to run the entry sequence
//   vec         vector of the selected channel, qualified by the vec_vld strobe
//   en_int      global interrupt enable
//   pending     latched requests
//   in_service  in-service register
//   nest_lvl    popcount of in_service
module vec_int_ctrl #(
   parameter int               NCH        = 4,
   parameter int               VEC_W      = 8,
   parameter logic [VEC_W-1:0] VEC_BASE   = 8'hE0,
   parameter int               VEC_STRIDE = 4,
   parameter bit               NEST       = 1'b1
) (
   input  logic                       t3,
   input  logic                       clr,
   input  logic [NCH-1:0]             pulse,
   input  logic                       mask_wr,
   input  logic [NCH-1:0]             mask_in,
   input  logic                       ei,
   input  logic                       di,
   input  logic                       boundary,
   input  logic                       int_ack,
   input  logic                       iret,
   output logic                       int_req,
   output logic [VEC_W-1:0]           vec,
   output logic                       vec_vld,
   output logic                       en_int,
   output logic [NCH-1:0]             pending,
   output logic [NCH-1:0]             in_service,
   output logic [$clog2(NCH+1)-1:0]   nest_lvl
);

   localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int LVL_W = $clog2(NCH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ENTRY = 2'd2
   } state_t;

   state_t             state;
   logic [SEL_W-1:0]   sel;
   logic [NCH-1:0]     mask;

   // Two-flop synchroniser plus one history flop for edge detection.
   logic [NCH-1:0]     sync1;
   logic [NCH-1:0]     sync2;
   logic [NCH-1:0]     sync3;
   logic [NCH-1:0]     rise;

   logic [NCH-1:0]     higher;
   logic [NCH-1:0]     elig;
   logic [SEL_W-1:0]   pick;
   logic [NCH-1:0]     sel_oh;
   logic [NCH-1:0]     iret_clr;
   logic [NCH-1:0]     entry_set;
   logic [NCH-1:0]     pending_nxt;
   logic [NCH-1:0]     in_service_nxt;
   logic               entry_go;
   logic               take;
   logic [VEC_W-1:0]   vec_calc;

   function automatic logic [LVL_W-1:0] popcnt(input logic [NCH-1:0] v);
      logic [LVL_W-1:0] c;
      c = '0;
      for (int i = 0; i < NCH; i++) begin
         c = c + LVL_W'(v[i]);
      end
      return c;
   endfunction

   assign rise = sync2 & ~sync3;

   // The ENTRY side effects (pending clear, in_service set, en_int clear)
   // are applied on the same edge that raises vec_vld, so they are visible
   // together with the vector.
   assign entry_go = (state == REQ) && int_ack;

   // Channels strictly higher in priority than the highest in-service one.
   // Index 0 is the highest priority, so bit i stays eligible only while no
   // in_service bit at index <= i is set.
   always_comb begin
      logic blk;
      blk    = 1'b0;
      higher = '0;
      for (int i = 0; i < NCH; i++) begin
         blk       = blk | in_service[i];
         higher[i] = ~blk;
      end
      if (!NEST) begin
         higher = (in_service == '0) ? '1 : '0;
      end
   end

   // The registered mask is used, so a mask_wr in the decision cycle does
   // not influence that decision.
   assign elig = pending & ~mask & higher;
   assign take = (state == IDLE) && en_int && (|elig) && boundary;

   // Lowest set index of elig wins.
   always_comb begin
      logic found;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (elig[i] && !found) begin
            pick  = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

   // One-hot of the highest-priority in-service bit, taken from the
   // pre-update register so a same-cycle ENTRY set is never cleared.
   always_comb begin
      logic found;
      found    = 1'b0;
      iret_clr = '0;
      for (int i = 0; i < NCH; i++) begin
         iret_clr[i] = in_service[i] & ~found;
         found       = found | in_service[i];
      end
   end

   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_oh[i] = (sel == SEL_W'(i));
      end
   end

   assign entry_set = entry_go ? sel_oh : '0;

   // A fresh edge on sel during entry re-sets the bit after the clear.
   assign pending_nxt    = (pending & ~entry_set) | rise;
   assign in_service_nxt = (in_service & ~(iret ? iret_clr : '0)) | entry_set;

   // Overflow beyond VEC_W bits is intentionally dropped.
   assign vec_calc = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(sel);

   // Capture, mask, in-service and global-enable state.
   always_ff @(negedge t3 or negedge clr) begin
      if (!clr) begin
         sync1      <= '0;
         sync2      <= '0;
         sync3      <= '0;
         pending    <= '0;
         in_service <= '0;
         nest_lvl   <= '0;
         mask       <= '0;
         en_int     <= 1'b1;
      end else begin
         sync1      <= pulse;
         sync2      <= sync1;
         sync3      <= sync2;
         pending    <= pending_nxt;
         in_service <= in_service_nxt;
         nest_lvl   <= popcnt(in_service_nxt);
         if (mask_wr) begin
            mask <= mask_in;
         end
         if (entry_go) begin
            en_int <= 1'b0;
         end else if (di) begin
            en_int <= 1'b0;
         end else if (ei || iret) begin
            en_int <= 1'b1;
         end
      end
   end

   // Request handshake FSM. sel is frozen from IDLE->REQ until the entry
   // completes; nothing in REQ except int_ack moves the machine.
   always_ff @(negedge t3 or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         sel     <= '0;
         int_req <= 1'b0;
         vec_vld <= 1'b0;
         vec     <= VEC_BASE;
      end else begin
         vec_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  state   <= REQ;
                  sel     <= pick;
                  int_req <= 1'b1;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state   <= ENTRY;
                  int_req <= 1'b0;
                  vec_vld <= 1'b1;
                  vec     <= vec_calc;
               end
            end
            ENTRY: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               int_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
